smem_bck_stage3: RTL and testbench

Backward-extension fetch stage of the SMEM pipeline, directly downstream of the backward control stage. For every BCK_RUN beat it reads the pending interval {k,l,s} at `{read_num, current_rd_addr}` from the interval RAM and the query base at `{read_num, backward_i}` from the read buffer. It aligns both 1-cycle-latency RAM results with the control bundle and hands the merged beat to the occurrence-lookup stage. It is a 2-deep registered pipeline under a global `stall`, with a hold register for RAM data that returns while stalled.

---
 rtl/smem_pkg.sv | 35 +++
 rtl/smem_stall_hold.sv | 49 ++++
 rtl/smem_bck_stage3.sv | 256 +++++++++++++++++++++++++
 tb/tb_smem_bck_stage3.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/smem_pkg.sv
// smem_pkg: shared definitions for the SMEM backward-extension stages.
//   - one-hot stage status encodings (BUBBLE is all zeros)
//   - pass-through sideband type and width
//   - interval record {k, l, s}
//   - helper that flags an ambiguous (N) base byte
package smem_pkg;

    localparam int STATUS_W = 6;
    localparam int SIDE_W   = 372;

    localparam logic [STATUS_W-1:0] ST_BUBBLE  = 6'b000000;
    localparam logic [STATUS_W-1:0] ST_F_INIT  = 6'b000001;
    localparam logic [STATUS_W-1:0] ST_F_RUN   = 6'b000010;
    localparam logic [STATUS_W-1:0] ST_F_BREAK = 6'b000100;
    localparam logic [STATUS_W-1:0] ST_BCK_INI = 6'b001000;
    localparam logic [STATUS_W-1:0] ST_BCK_RUN = 6'b010000;
    localparam logic [STATUS_W-1:0] ST_BCK_END = 6'b100000;

    typedef logic [SIDE_W-1:0] side_t;

    typedef struct packed {
        logic [63:0] k;
        logic [63:0] l;
        logic [63:0] s;
    } ivl_t;

    // Held bundle: interval record followed by the raw read-buffer byte.
    localparam int HOLD_W = $bits(ivl_t) + 8;

    // Base bytes 0..3 are A/C/G/T; anything larger is an N.
    function automatic logic is_ambig(input logic [7:0] b);
        return (b > 8'd3);
    endfunction

endpackage

// File: rtl/smem_stall_hold.sv
// smem_stall_hold: single-entry capture register with a valid bit.
// Catches RAM read data that returns while the pipeline is stalled so the
// beat waiting in the stage ahead can pick it up once the stall drops.
//   clk, rst     : clock, synchronous active-low reset
//   capture      : load d and set hold_v
//   consume      : clear hold_v (data is being taken downstream this edge)
//   d            : data to capture
//   q            : held data
//   hold_v       : q is valid
module smem_stall_hold #(
    parameter int W = 200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         capture,
    input  logic         consume,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         hold_v
);

    logic [W-1:0] data_d, data_q;
    logic         hold_v_d, hold_v_q;

    always_comb begin
        data_d   = data_q;
        hold_v_d = hold_v_q;
        if (capture) begin
            data_d   = d;
            hold_v_d = 1'b1;
        end else if (consume) begin
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q   <= '0;
            hold_v_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            hold_v_q <= hold_v_d;
        end
    end

    assign q      = data_q;
    assign hold_v = hold_v_q;

endmodule

// File: rtl/smem_bck_stage3.sv
// smem_bck_stage3: backward-extension fetch stage.
// Issues interval-RAM and read-buffer reads for every BCK_RUN beat, aligns
// the 1-cycle-latency results with the control bundle through two register
// stages (A: issue, B: outputs) and hands the merged beat downstream.
// All stage registers hold under stall; RAM data returning during a stall
// is parked in smem_stall_hold.
//   inputs : clk, rst (sync, active-low), stall, control bundle *_q, side_q,
//            ivl_rd_data (192b {k,l,s}), rdb_rd_data (base byte)
//   outputs: ivl/rdb read strobes and addresses, aligned control bundle,
//            ik_k/ik_l/ik_s, base, ambig, reads_done
module smem_bck_stage3
    import smem_pkg::*;
#(
    parameter int READ_NUM_WIDTH = 8,
    parameter int SIDE_W         = smem_pkg::SIDE_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic [5:0]                  status_q,
    input  logic [READ_NUM_WIDTH-1:0]   read_num_q,
    input  logic [6:0]                  current_rd_addr_q,
    input  logic [6:0]                  backward_i_q,
    input  logic [6:0]                  backward_j_q,
    input  logic                        finish_sign_q,
    input  logic                        iteration_boundary_q,
    input  logic [SIDE_W-1:0]           side_q,
    output logic                        ivl_rd_en,
    output logic [READ_NUM_WIDTH+6:0]   ivl_rd_addr,
    input  logic [191:0]                ivl_rd_data,
    output logic                        rdb_rd_en,
    output logic [READ_NUM_WIDTH+6:0]   rdb_rd_addr,
    input  logic [7:0]                  rdb_rd_data,
    output logic [5:0]                  status,
    output logic [READ_NUM_WIDTH-1:0]   read_num,
    output logic [6:0]                  backward_i,
    output logic [6:0]                  backward_j,
    output logic                        finish_sign,
    output logic                        iteration_boundary,
    output logic [SIDE_W-1:0]           side,
    output logic [63:0]                 ik_k,
    output logic [63:0]                 ik_l,
    output logic [63:0]                 ik_s,
    output logic [1:0]                  base,
    output logic                        ambig,
    output logic [7:0]                  reads_done
);

    logic in_run, in_ini, rd_go;

    assign in_run = (status_q == ST_BCK_RUN);
    assign in_ini = (status_q == ST_BCK_INI);
    // rst gates the strobe so nothing is read while reset is held.
    assign rd_go  = in_run & ~stall & rst;

    assign ivl_rd_en   = rd_go;
    assign rdb_rd_en   = rd_go;
    assign ivl_rd_addr = {read_num_q, current_rd_addr_q};
    assign rdb_rd_addr = {read_num_q, backward_i_q};

    // ---------------- stage A ----------------
    logic [5:0]                a_status_d, a_status_q;
    logic [READ_NUM_WIDTH-1:0] a_read_num_d, a_read_num_q;
    logic [6:0]                a_bi_d, a_bi_q;
    logic [6:0]                a_bj_d, a_bj_q;
    logic                      a_fin_d, a_fin_q;
    logic                      a_ib_d, a_ib_q;
    logic [SIDE_W-1:0]         a_side_d, a_side_q;
    logic                      a_run_d, a_run_q;
    logic                      rd_pend_d, rd_pend_q;

    always_comb begin
        a_status_d   = a_status_q;
        a_read_num_d = a_read_num_q;
        a_bi_d       = a_bi_q;
        a_bj_d       = a_bj_q;
        a_fin_d      = a_fin_q;
        a_ib_d       = a_ib_q;
        a_side_d     = a_side_q;
        a_run_d      = a_run_q;
        if (!stall) begin
            a_status_d   = ST_BUBBLE;
            a_read_num_d = '0;
            a_bi_d       = '0;
            a_bj_d       = '0;
            a_fin_d      = 1'b0;
            a_ib_d       = 1'b0;
            a_side_d     = '0;
            a_run_d      = 1'b0;
            if (in_run || in_ini) begin
                a_status_d   = status_q;
                a_read_num_d = read_num_q;
                a_bi_d       = backward_i_q;
                a_bj_d       = backward_j_q;
                // An INI beat never completes a read.
                a_fin_d      = in_run & finish_sign_q;
                a_ib_d       = iteration_boundary_q;
                a_side_d     = side_q;
                a_run_d      = in_run;
            end
        end
    end

    // Marks the cycle in which RAM data for the beat in stage A is on the bus.
    assign rd_pend_d = rd_go;

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_status_q   <= ST_BUBBLE;
            a_read_num_q <= '0;
            a_bi_q       <= '0;
            a_bj_q       <= '0;
            a_fin_q      <= 1'b0;
            a_ib_q       <= 1'b0;
            a_side_q     <= '0;
            a_run_q      <= 1'b0;
            rd_pend_q    <= 1'b0;
        end else begin
            a_status_q   <= a_status_d;
            a_read_num_q <= a_read_num_d;
            a_bi_q       <= a_bi_d;
            a_bj_q       <= a_bj_d;
            a_fin_q      <= a_fin_d;
            a_ib_q       <= a_ib_d;
            a_side_q     <= a_side_d;
            a_run_q      <= a_run_d;
            rd_pend_q    <= rd_pend_d;
        end
    end

    // ---------------- hold register ----------------
    logic [HOLD_W-1:0] live_bundle, held_bundle, fetch_bundle;
    logic              hold_v;
    ivl_t              fetch_ivl;
    logic [7:0]        fetch_byte;

    assign live_bundle = {ivl_rd_data, rdb_rd_data};

    // Reads are never issued under stall, so at most one capture happens
    // before the next unstalled edge consumes it.
    smem_stall_hold #(.W(HOLD_W)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .capture (stall & rd_pend_q),
        .consume (~stall),
        .d       (live_bundle),
        .q       (held_bundle),
        .hold_v  (hold_v)
    );

    assign fetch_bundle = hold_v ? held_bundle : live_bundle;
    assign fetch_ivl    = fetch_bundle[HOLD_W-1:8];
    assign fetch_byte   = fetch_bundle[7:0];

    // ---------------- stage B ----------------
    logic [5:0]                b_status_d, b_status_q;
    logic [READ_NUM_WIDTH-1:0] b_read_num_d, b_read_num_q;
    logic [6:0]                b_bi_d, b_bi_q;
    logic [6:0]                b_bj_d, b_bj_q;
    logic                      b_fin_d, b_fin_q;
    logic                      b_ib_d, b_ib_q;
    logic [SIDE_W-1:0]         b_side_d, b_side_q;
    logic [63:0]               b_k_d, b_k_q;
    logic [63:0]               b_l_d, b_l_q;
    logic [63:0]               b_s_d, b_s_q;
    logic [1:0]                b_base_d, b_base_q;
    logic                      b_ambig_d, b_ambig_q;
    logic [7:0]                reads_done_d, reads_done_q;

    always_comb begin
        b_status_d   = b_status_q;
        b_read_num_d = b_read_num_q;
        b_bi_d       = b_bi_q;
        b_bj_d       = b_bj_q;
        b_fin_d      = b_fin_q;
        b_ib_d       = b_ib_q;
        b_side_d     = b_side_q;
        b_k_d        = b_k_q;
        b_l_d        = b_l_q;
        b_s_d        = b_s_q;
        b_base_d     = b_base_q;
        b_ambig_d    = b_ambig_q;
        reads_done_d = reads_done_q;
        if (!stall) begin
            b_status_d   = a_status_q;
            b_read_num_d = a_read_num_q;
            b_bi_d       = a_bi_q;
            b_bj_d       = a_bj_q;
            b_fin_d      = a_fin_q;
            b_ib_d       = a_ib_q;
            b_side_d     = a_side_q;
            b_k_d        = '0;
            b_l_d        = '0;
            b_s_d        = '0;
            b_base_d     = '0;
            b_ambig_d    = 1'b0;
            if (a_run_q) begin
                b_k_d     = fetch_ivl.k;
                b_l_d     = fetch_ivl.l;
                b_s_d     = fetch_ivl.s;
                b_base_d  = fetch_byte[1:0];
                b_ambig_d = is_ambig(fetch_byte);
            end
            if (a_fin_q) begin
                reads_done_d = reads_done_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            b_status_q   <= ST_BUBBLE;
            b_read_num_q <= '0;
            b_bi_q       <= '0;
            b_bj_q       <= '0;
            b_fin_q      <= 1'b0;
            b_ib_q       <= 1'b0;
            b_side_q     <= '0;
            b_k_q        <= '0;
            b_l_q        <= '0;
            b_s_q        <= '0;
            b_base_q     <= '0;
            b_ambig_q    <= 1'b0;
            reads_done_q <= '0;
        end else begin
            b_status_q   <= b_status_d;
            b_read_num_q <= b_read_num_d;
            b_bi_q       <= b_bi_d;
            b_bj_q       <= b_bj_d;
            b_fin_q      <= b_fin_d;
            b_ib_q       <= b_ib_d;
            b_side_q     <= b_side_d;
            b_k_q        <= b_k_d;
            b_l_q        <= b_l_d;
            b_s_q        <= b_s_d;
            b_base_q     <= b_base_d;
            b_ambig_q    <= b_ambig_d;
            reads_done_q <= reads_done_d;
        end
    end

    assign status             = b_status_q;
    assign read_num           = b_read_num_q;
    assign backward_i         = b_bi_q;
    assign backward_j         = b_bj_q;
    assign finish_sign        = b_fin_q;
    assign iteration_boundary = b_ib_q;
    assign side               = b_side_q;
    assign ik_k               = b_k_q;
    assign ik_l               = b_l_q;
    assign ik_s               = b_s_q;
    assign base               = b_base_q;
    assign ambig              = b_ambig_q;
    assign reads_done         = reads_done_q;

endmodule

// File: tb/tb_smem_bck_stage3.sv
// Directed bench for smem_bck_stage3 with behavioural 1-cycle-latency RAMs.
module tb_smem_bck_stage3;

    localparam logic [5:0] S_BUB = 6'b000000;
    localparam logic [5:0] S_FRN = 6'b000010;
    localparam logic [5:0] S_INI = 6'b001000;
    localparam logic [5:0] S_RUN = 6'b010000;
    localparam logic [191:0] JUNK_IVL = {3{64'hDEAD_BEEF_0BAD_F00D}};
    localparam logic [191:0] MISS_IVL = {3{64'hFFFF_0000_FFFF_0000}};

    logic         clk = 1'b0;
    logic         rst, stall;
    logic [5:0]   status_q;
    logic [7:0]   read_num_q;
    logic [6:0]   current_rd_addr_q, backward_i_q, backward_j_q;
    logic         finish_sign_q, iteration_boundary_q;
    logic [371:0] side_q;
    logic         ivl_rd_en, rdb_rd_en;
    logic [14:0]  ivl_rd_addr, rdb_rd_addr;
    logic [191:0] ivl_rd_data = '0;
    logic [7:0]   rdb_rd_data = '0;
    logic [5:0]   status;
    logic [7:0]   read_num;
    logic [6:0]   backward_i, backward_j;
    logic         finish_sign, iteration_boundary;
    logic [371:0] side;
    logic [63:0]  ik_k, ik_l, ik_s;
    logic [1:0]   base;
    logic         ambig;
    logic [7:0]   reads_done;

    int n_checks = 0;
    int n_errors = 0;
    int n_strobes = 0;

    logic [191:0] ivl_mem [int];
    logic [7:0]   rdb_mem [int];

    smem_bck_stage3 dut (
        .clk(clk), .rst(rst), .stall(stall),
        .status_q(status_q), .read_num_q(read_num_q),
        .current_rd_addr_q(current_rd_addr_q),
        .backward_i_q(backward_i_q), .backward_j_q(backward_j_q),
        .finish_sign_q(finish_sign_q), .iteration_boundary_q(iteration_boundary_q),
        .side_q(side_q),
        .ivl_rd_en(ivl_rd_en), .ivl_rd_addr(ivl_rd_addr), .ivl_rd_data(ivl_rd_data),
        .rdb_rd_en(rdb_rd_en), .rdb_rd_addr(rdb_rd_addr), .rdb_rd_data(rdb_rd_data),
        .status(status), .read_num(read_num),
        .backward_i(backward_i), .backward_j(backward_j),
        .finish_sign(finish_sign), .iteration_boundary(iteration_boundary),
        .side(side), .ik_k(ik_k), .ik_l(ik_l), .ik_s(ik_s),
        .base(base), .ambig(ambig), .reads_done(reads_done)
    );

    always #5 clk = ~clk;

    // RAM models: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (ivl_rd_en) begin
            ivl_rd_data <= ivl_mem.exists(int'(ivl_rd_addr)) ? ivl_mem[int'(ivl_rd_addr)] : MISS_IVL;
        end else begin
            ivl_rd_data <= JUNK_IVL;
        end
        if (rdb_rd_en) begin
            rdb_rd_data <= rdb_mem.exists(int'(rdb_rd_addr)) ? rdb_mem[int'(rdb_rd_addr)] : 8'h00;
        end else begin
            rdb_rd_data <= 8'hEE;
        end
        if (ivl_rd_en || rdb_rd_en) n_strobes <= n_strobes + 1;
    end

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [371:0] mk_side(input int n);
        logic [383:0] t;
        t = {12{32'h5A5AC3C3 ^ n}};
        return t[371:0];
    endfunction

    task automatic drive(input logic [5:0] st, input logic [7:0] rn, input logic [6:0] ra,
                         input logic [6:0] bi, input logic [6:0] bj, input logic fin,
                         input logic ib, input logic [371:0] sd);
        status_q = st; read_num_q = rn; current_rd_addr_q = ra;
        backward_i_q = bi; backward_j_q = bj; finish_sign_q = fin;
        iteration_boundary_q = ib; side_q = sd;
    endtask

    task automatic drive_bubble();
        drive(S_BUB, 8'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, '0);
    endtask

    task automatic set_mem(input logic [7:0] rn, input logic [6:0] ra, input logic [6:0] bi,
                           input logic [63:0] k, input logic [63:0] l, input logic [63:0] s,
                           input logic [7:0] b);
        ivl_mem[int'({rn, ra})] = {k, l, s};
        rdb_mem[int'({rn, bi})] = b;
    endtask

    task automatic expect_beat(input string tag, input logic [5:0] st, input logic [7:0] rn,
                               input logic [6:0] bi, input logic [6:0] bj, input logic fin,
                               input logic ib, input logic [371:0] sd, input logic [63:0] k,
                               input logic [63:0] l, input logic [63:0] s, input logic [7:0] b);
        chk({tag, ".status"}, status, st);
        chk({tag, ".read_num"}, read_num, rn);
        chk({tag, ".bi"}, backward_i, bi);
        chk({tag, ".bj"}, backward_j, bj);
        chk({tag, ".fin"}, finish_sign, fin);
        chk({tag, ".ib"}, iteration_boundary, ib);
        chk({tag, ".side"}, side, sd);
        chk({tag, ".k"}, ik_k, k);
        chk({tag, ".l"}, ik_l, l);
        chk({tag, ".s"}, ik_s, s);
        chk({tag, ".base"}, base, b[1:0]);
        chk({tag, ".ambig"}, ambig, (b > 8'd3));
    endtask

    task automatic expect_bubble(input string tag);
        expect_beat(tag, S_BUB, 8'd0, 7'd0, 7'd0, 1'b0, 1'b0, '0, 64'd0, 64'd0, 64'd0, 8'd0);
    endtask

    initial begin
        // Reset: strobes held low even with a BCK_RUN input.
        rst = 1'b0; stall = 1'b0;
        drive(S_RUN, 8'd1, 7'd1, 7'd1, 7'd1, 1'b1, 1'b1, mk_side(1));
        #1;
        chk("rst.ivl_en", ivl_rd_en, 1'b0);
        chk("rst.rdb_en", rdb_rd_en, 1'b0);
        tick(); tick();
        expect_bubble("rst");
        chk("rst.reads_done", reads_done, 8'd0);
        rst = 1'b1;
        drive_bubble();
        tick(); tick();

        // Single BCK_RUN beat, latency 2.
        set_mem(8'd3, 7'd5, 7'd10, 64'h11, 64'h22, 64'h33, 8'h02);
        drive(S_RUN, 8'd3, 7'd5, 7'd10, 7'd7, 1'b0, 1'b1, mk_side(2));
        #1;
        chk("single.ivl_en", ivl_rd_en, 1'b1);
        chk("single.rdb_en", rdb_rd_en, 1'b1);
        chk("single.ivl_addr", ivl_rd_addr, 15'h185);
        chk("single.rdb_addr", rdb_rd_addr, 15'h18A);
        tick();
        drive_bubble();
        chk("single.t1_status", status, S_BUB);
        tick();
        expect_beat("single", S_RUN, 8'd3, 7'd10, 7'd7, 1'b0, 1'b1, mk_side(2),
                    64'h11, 64'h22, 64'h33, 8'h02);
        tick(); tick();

        // Four back-to-back beats.
        for (int n = 0; n < 4; n++)
            set_mem(8'd1, 7'(20 + n), 7'(30 + n), 64'h100 + 64'(n), 64'h200 + 64'(n),
                    64'h300 + 64'(n), 8'(n));
        for (int c = 0; c < 6; c++) begin
            if (c < 4) drive(S_RUN, 8'd1, 7'(20 + c), 7'(30 + c), 7'(c), 1'b0, c[0], mk_side(10 + c));
            else drive_bubble();
            tick();
            if (c >= 1 && c <= 4)
                expect_beat($sformatf("b2b%0d", c - 1), S_RUN, 8'd1, 7'(29 + c), 7'(c - 1), 1'b0,
                            c[0] ^ 1'b1, mk_side(9 + c), 64'h100 + 64'(c - 1),
                            64'h200 + 64'(c - 1), 64'h300 + 64'(c - 1), 8'(c - 1));
        end
        tick();

        // Stall for 3 cycles right after issue; a second beat waits under stall.
        set_mem(8'd4, 7'd40, 7'd50, 64'hAAA1, 64'hAAA2, 64'hAAA3, 8'h01);
        set_mem(8'd4, 7'd41, 7'd51, 64'hBBB1, 64'hBBB2, 64'hBBB3, 8'h03);
        drive(S_RUN, 8'd4, 7'd40, 7'd50, 7'd1, 1'b0, 1'b1, mk_side(40));
        tick();
        stall = 1'b1;
        drive(S_RUN, 8'd4, 7'd41, 7'd51, 7'd2, 1'b0, 1'b0, mk_side(41));
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d.ivl_en", c), ivl_rd_en, 1'b0);
            tick();
            expect_bubble($sformatf("stall%0d.frozen", c));
        end
        stall = 1'b0;
        #1;
        chk("stall.release_en", ivl_rd_en, 1'b1);
        tick();
        drive_bubble();
        expect_beat("stall.held", S_RUN, 8'd4, 7'd50, 7'd1, 1'b0, 1'b1, mk_side(40),
                    64'hAAA1, 64'hAAA2, 64'hAAA3, 8'h01);
        tick();
        expect_beat("stall.next", S_RUN, 8'd4, 7'd51, 7'd2, 1'b0, 1'b0, mk_side(41),
                    64'hBBB1, 64'hBBB2, 64'hBBB3, 8'h03);
        tick(); tick();

        // Non-run statuses: no strobes, INI passes with zero data, others bubble.
        n_strobes = 0;
        drive(S_INI, 8'd2, 7'd3, 7'd4, 7'd9, 1'b1, 1'b1, mk_side(50));
        tick();
        drive(S_BUB, 8'd7, 7'd7, 7'd7, 7'd7, 1'b1, 1'b1, mk_side(51));
        tick();
        expect_beat("ini", S_INI, 8'd2, 7'd4, 7'd9, 1'b0, 1'b1, mk_side(50),
                    64'd0, 64'd0, 64'd0, 8'd0);
        drive(S_FRN, 8'd9, 7'd9, 7'd9, 7'd9, 1'b1, 1'b1, mk_side(52));
        tick();
        expect_bubble("nonrun.bubble");
        drive_bubble();
        tick();
        expect_bubble("nonrun.frun");
        chk("nonrun.strobes", n_strobes, 0);
        chk("nonrun.reads_done", reads_done, 8'd0);
        tick();

        // Ambiguous base and the A/C/G/T boundary.
        set_mem(8'd6, 7'd7, 7'd8, 64'h4441, 64'h4442, 64'h4443, 8'h04);
        set_mem(8'd6, 7'd9, 7'd11, 64'h5551, 64'h5552, 64'h5553, 8'h03);
        drive(S_RUN, 8'd6, 7'd7, 7'd8, 7'd0, 1'b0, 1'b0, mk_side(60));
        tick();
        drive(S_RUN, 8'd6, 7'd9, 7'd11, 7'd0, 1'b0, 1'b0, mk_side(61));
        tick();
        drive_bubble();
        chk("ambig4.ambig", ambig, 1'b1);
        chk("ambig4.base", base, 2'd0);
        chk("ambig4.k", ik_k, 64'h4441);
        tick();
        chk("base3.ambig", ambig, 1'b0);
        chk("base3.base", base, 2'd3);
        tick(); tick();

        // reads_done counts finished beats and wraps after 255.
        for (int n = 0; n < 255; n++) begin
            drive(S_RUN, 8'd5, 7'(n), 7'(n), 7'd0, 1'b1, 1'b0, '0);
            tick();
        end
        drive_bubble();
        tick();
        chk("reads_done.255", reads_done, 8'd255);
        drive(S_RUN, 8'd5, 7'd0, 7'd0, 7'd0, 1'b1, 1'b0, '0);
        tick();
        drive_bubble();
        tick();
        chk("reads_done.wrap", reads_done, 8'd0);
        tick();

        // Reset mid-stream discards in-flight beats.
        set_mem(8'd7, 7'd1, 7'd1, 64'h7771, 64'h7772, 64'h7773, 8'h01);
        for (int n = 0; n < 3; n++) begin
            drive(S_RUN, 8'd7, 7'd1, 7'd1, 7'd0, 1'b1, 1'b1, mk_side(70));
            tick();
        end
        chk("midrst.pre_reads_done", reads_done, 8'd2);
        rst = 1'b0;
        #1;
        chk("midrst.ivl_en", ivl_rd_en, 1'b0);
        tick();
        expect_bubble("midrst");
        chk("midrst.reads_done", reads_done, 8'd0);
        rst = 1'b1;
        drive_bubble();
        tick();
        expect_bubble("midrst.after1");
        tick();
        expect_bubble("midrst.after2");
        chk("midrst.reads_done2", reads_done, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
